exe_mdu_iter: RTL and testbench

- Parametrised multiply/divide unit for the EXE stage. It replaces the fixed 32-bit multiplier/divider and adds multiply-accumulate and multiply-subtract, a configurable divider radix, a configurable multiplier pipeline depth, and a divide-by-zero early-out.
- It stalls EXE while busy and returns a HI/LO pair with a one-cycle done pulse. HI/LO register update stays outside this block.

---
 rtl/exe_mdu_iter_if.sv | 28 ++
 rtl/exe_mdu_iter.sv | 166 ++++++++++++++++
 tb/tb_exe_mdu_iter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_mdu_iter_if.sv
// Request/response bundle between the EXE stage and the iterative multiply/divide unit.
// The master is the EXE stage, and the slave is the MDU.
interface exe_mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] lo_in;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output flush, start, op, src_a, src_b, hi_in, lo_in,
        input  stall, busy, done, result_hi, result_lo
    );

    modport slave (
        input  flush, start, op, src_a, src_b, hi_in, lo_in,
        output stall, busy, done, result_hi, result_lo
    );
endinterface

// File: rtl/exe_mdu_iter.sv
// Iterative multiply / multiply-accumulate / restoring-divide unit for the EXE stage.
// state | meaning
// IDLE  | waiting for an accepted MDU instruction
// MUL   | multiply latency down-count
// DIV   | restoring divide iterations on operand magnitudes
// FIX   | apply quotient/remainder signs
// DONE  | result valid, done pulse
module exe_mdu_iter #(
    parameter int WIDTH       = 32,
    parameter int DIV_BITS    = 1,
    parameter int MUL_LATENCY = 2
) (
    input  logic          clk,
    input  logic          resetn,
    exe_mdu_iter_if.slave mdu
);
    localparam int N        = WIDTH / DIV_BITS;
    localparam int CMAX     = (N > MUL_LATENCY) ? N : MUL_LATENCY;
    localparam int CW       = $clog2(CMAX + 1);
    localparam int MUL_LOAD = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] res_hi, res_lo;

    logic             accept, is_div_in, b_zero_in, in_signed, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b, m_hi, m_lo;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
    logic [WIDTH:0]   r_t;
    logic [WIDTH-1:0] q_t, q_fix, r_fix;

    always_comb begin
        is_div_in = (mdu.op[2:1] == 2'b01);
        b_zero_in = (mdu.src_b == '0);
        in_signed = ~mdu.op[0];
        accept    = (state == S_IDLE) & mdu.start & ~mdu.flush;
        a_neg_in  = in_signed & mdu.src_a[WIDTH-1];
        b_neg_in  = in_signed & mdu.src_b[WIDTH-1];
        mag_a     = a_neg_in ? -mdu.src_a : mdu.src_a;
        mag_b     = b_neg_in ? -mdu.src_b : mdu.src_b;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mdu.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (mdu.start) begin
                    if (is_div_in)             state_nxt = b_zero_in ? S_DONE : S_DIV;
                    else if (MUL_LATENCY == 1) state_nxt = S_DONE;
                    else                       state_nxt = S_MUL;
                end
                S_MUL:   if (cnt == '0) state_nxt = S_DONE;
                S_DIV:   if (cnt == '0) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // With single-cycle multiply the result is formed in IDLE, before operands are latched.
    always_comb begin
        m_op  = (state == S_IDLE) ? mdu.op    : op_q;
        m_a   = (state == S_IDLE) ? mdu.src_a : a_q;
        m_b   = (state == S_IDLE) ? mdu.src_b : b_q;
        m_hi  = (state == S_IDLE) ? mdu.hi_in : hi_q;
        m_lo  = (state == S_IDLE) ? mdu.lo_in : lo_q;
        ext_a = ~m_op[0] ? {{WIDTH{m_a[WIDTH-1]}}, m_a} : {{WIDTH{1'b0}}, m_a};
        ext_b = ~m_op[0] ? {{WIDTH{m_b[WIDTH-1]}}, m_b} : {{WIDTH{1'b0}}, m_b};
        prod  = ext_a * ext_b;
        case (m_op[2:1])
            2'b10:   mul_res = {m_hi, m_lo} + prod;
            2'b11:   mul_res = {m_hi, m_lo} - prod;
            default: mul_res = prod;
        endcase
    end

    always_comb begin
        r_t = {1'b0, rem_q};
        q_t = quo_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
            q_t = {q_t[WIDTH-2:0], 1'b0};
            if (r_t >= {1'b0, dvs_q}) begin
                r_t    = r_t - {1'b0, dvs_q};
                q_t[0] = 1'b1;
            end
        end
        q_fix = q_neg ? -quo_q : quo_q;
        r_fix = r_neg ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            if (accept) begin
                op_q  <= mdu.op;
                a_q   <= mdu.src_a;
                b_q   <= mdu.src_b;
                hi_q  <= mdu.hi_in;
                lo_q  <= mdu.lo_in;
                rem_q <= '0;
                quo_q <= mag_a;
                dvs_q <= mag_b;
                q_neg <= a_neg_in ^ b_neg_in;
                r_neg <= a_neg_in;
                cnt   <= is_div_in ? CW'(N - 1) : CW'(MUL_LOAD);
            end else if ((state == S_MUL || state == S_DIV) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == S_DIV) begin
                rem_q <= r_t[WIDTH-1:0];
                quo_q <= q_t;
            end
            // state_nxt is only DONE when no flush is present.
            if (state_nxt == S_DONE) begin
                if (state == S_FIX) begin
                    res_hi <= r_fix;
                    res_lo <= q_fix;
                end else if (state == S_IDLE && is_div_in) begin
                    res_hi <= mdu.src_a;
                    res_lo <= '1;
                end else begin
                    res_hi <= mul_res[2*WIDTH-1:WIDTH];
                    res_lo <= mul_res[WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        mdu.busy      = (state != S_IDLE);
        mdu.done      = (state == S_DONE) & ~mdu.flush;
        mdu.stall     = mdu.start & ~mdu.done & ~mdu.flush;
        mdu.result_hi = res_hi;
        mdu.result_lo = res_lo;
    end
endmodule

// File: tb/tb_exe_mdu_iter.sv
// Random and directed bench for exe_mdu_iter. Two instances (radix-2/lat-2 and radix-4/lat-4)
// see the same stimulus and are compared against an arithmetic reference model.
module tb_exe_mdu_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exe_mdu_iter_if #(.WIDTH(W)) if1 ();
    exe_mdu_iter_if #(.WIDTH(W)) if2 ();

    assign if2.flush = if1.flush;
    assign if2.start = if1.start;
    assign if2.op    = if1.op;
    assign if2.src_a = if1.src_a;
    assign if2.src_b = if1.src_b;
    assign if2.hi_in = if1.hi_in;
    assign if2.lo_in = if1.lo_in;

    exe_mdu_iter #(.WIDTH(W), .DIV_BITS(1), .MUL_LATENCY(2)) u_dut_r2 (
        .clk(clk), .resetn(resetn), .mdu(if1));
    exe_mdu_iter #(.WIDTH(W), .DIV_BITS(2), .MUL_LATENCY(4)) u_dut_r4 (
        .clk(clk), .resetn(resetn), .mdu(if2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
        logic [63:0] p;
        if (op == 3'd2 || op == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 3'd3) return {a % b, a / b};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end
        if (op[0] == 1'b0) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else               p = {32'd0, a} * {32'd0, b};
        if (op == 3'd4 || op == 3'd5) return {hi, lo} + p;
        if (op == 3'd6 || op == 3'd7) return {hi, lo} - p;
        return p;
    endfunction

    function automatic int exp_lat(input int div_bits, input int mul_lat, input logic [2:0] op,
                                   input logic [31:0] b);
        if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 1 : W / div_bits + 2;
        return mul_lat;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs();
        if1.flush = 1'b0;
        if1.start = 1'b0;
        if1.op    = '0;
        if1.src_a = '0;
        if1.src_b = '0;
        if1.hi_in = '0;
        if1.lo_in = '0;
    endtask

    // Called at a falling edge; drives start in that cycle (cycle 0) and returns at a falling edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input bit hold);
        logic [63:0] exp_v, res1, res2;
        int lat1, lat2, el1, el2, n1, n2, c;
        exp_v = ref_mdu(op, a, b, hi, lo);
        el1 = exp_lat(1, 2, op, b);
        el2 = exp_lat(2, 4, op, b);
        lat1 = -1; lat2 = -1; n1 = 0; n2 = 0; c = 0;
        res1 = '0; res2 = '0;
        if1.flush = 1'b0;
        if1.start = 1'b1;
        if1.op = op; if1.src_a = a; if1.src_b = b; if1.hi_in = hi; if1.lo_in = lo;
        while (c < 60 && (lat1 < 0 || lat2 < 0)) begin
            #1;
            if (if1.done) begin
                n1++;
                if (lat1 < 0) begin lat1 = c; res1 = {if1.result_hi, if1.result_lo}; end
            end
            if (if2.done) begin
                n2++;
                if (lat2 < 0) begin lat2 = c; res2 = {if2.result_hi, if2.result_lo}; end
            end
            chk({tag, "/stall"}, 64'(if1.stall), 64'((c == 0) || (hold && c < el1)));
            if (c == 0) chk({tag, "/busy0"}, 64'({if1.busy, if2.busy}), 64'd0);
            if (c == 1) chk({tag, "/busy1"}, 64'({if1.busy, if2.busy}), 64'd3);
            @(negedge clk);
            c++;
            if1.start = hold && lat1 < 0;
            if1.op    = 3'($urandom);
            if1.src_a = $urandom;
            if1.src_b = $urandom;
            if1.hi_in = $urandom;
            if1.lo_in = $urandom;
        end
        if1.start = 1'b0;
        #1;
        chk({tag, "/lat_r2"}, 64'(lat1), 64'(el1));
        chk({tag, "/res_r2"}, res1, exp_v);
        chk({tag, "/lat_r4"}, 64'(lat2), 64'(el2));
        chk({tag, "/res_r4"}, res2, exp_v);
        chk({tag, "/ndone"}, 64'({n1[3:0], n2[3:0]}), 64'h11);
        chk({tag, "/held_r2"}, {if1.result_hi, if1.result_lo}, exp_v);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((if1.busy || if2.busy) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/idle"}, 64'({if1.busy, if2.busy}), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int nd, c;
        logic [2:0] rop;
        clear_inputs();
        #12;
        chk("rst/res_r2", {if1.result_hi, if1.result_lo}, 64'd0);
        chk("rst/ctl", 64'({if1.busy, if1.done, if1.stall, if2.busy, if2.done, if2.stall}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 1'b1);
        wait_idle("mult_neg3x5");
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        run_op("maddu_carry", 3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        wait_idle("maddu_carry");
        run_op("msub_2x3", 3'd6, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0);
        wait_idle("msub_2x3");
        run_op("div_by0", 3'd2, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op("divu_by0", 3'd3, 32'h8765_4321, 32'd0, 32'd0, 32'd0, 1'b0);

        // Flush in DIV cycle 10, then a new op is presented the following cycle.
        if1.start = 1'b1; if1.op = 3'd3; if1.src_a = 32'd1000; if1.src_b = 32'd3;
        nd = 0;
        for (int i = 0; i <= 10; i++) begin
            #1;
            nd += int'(if1.done) + int'(if2.done);
            if (i == 10) chk("flush/busy10", 64'({if1.busy, if2.busy}), 64'd3);
            @(negedge clk);
            if1.start = 1'b0;
            if (i == 9) if1.flush = 1'b1;
            if (i == 10) if1.flush = 1'b0;
        end
        chk("flush/no_done", 64'(nd), 64'd0);
        run_op("after_flush", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);

        // Flush together with start in IDLE: nothing accepted.
        if1.start = 1'b1; if1.flush = 1'b1; if1.op = 3'd0;
        #1;
        chk("flush_start/stall", 64'(if1.stall), 64'd0);
        @(negedge clk);
        if1.start = 1'b0; if1.flush = 1'b0;
        #1;
        chk("flush_start/busy", 64'({if1.busy, if2.busy}), 64'd0);
        @(negedge clk);

        // Flush during DONE of the latency-2 instance suppresses done.
        if1.start = 1'b1; if1.op = 3'd0; if1.src_a = 32'd2; if1.src_b = 32'd3;
        @(negedge clk);
        if1.start = 1'b0;
        @(negedge clk);
        if1.flush = 1'b1;
        #1;
        chk("flush_done/done", 64'({if1.done, if2.done}), 64'd0);
        @(negedge clk);
        if1.flush = 1'b0;
        #1;
        chk("flush_done/busy", 64'({if1.busy, if2.busy}), 64'd0);
        @(negedge clk);

        // Back-to-back MULT then DIVU with start held high.
        if1.start = 1'b1; if1.op = 3'd0; if1.src_a = 32'd7; if1.src_b = 32'd6;
        c = 0;
        #1;
        while (!if1.done && c < 20) begin
            @(negedge clk);
            c++;
            #1;
        end
        chk("b2b/mul_lat", 64'(c), 64'd2);
        chk("b2b/mul_res", {if1.result_hi, if1.result_lo}, 64'd42);
        @(negedge clk);
        if1.op = 3'd3; if1.src_a = 32'd100; if1.src_b = 32'd7;
        #1;
        chk("b2b/accept", 64'({if1.busy, if1.stall}), 64'b01);
        @(negedge clk);
        if1.start = 1'b0;
        c = 1;
        #1;
        while (!if1.done && c < 60) begin
            @(negedge clk);
            c++;
            #1;
        end
        chk("b2b/div_lat", 64'(c), 64'd34);
        chk("b2b/div_res", {if1.result_hi, if1.result_lo}, {32'd2, 32'd14});
        wait_idle("b2b");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, pick(), pick(), $urandom, $urandom,
                   1'b0);
            wait_idle($sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a divide.
        if1.start = 1'b1; if1.op = 3'd3; if1.src_a = 32'd100; if1.src_b = 32'd7;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst/res", {if1.result_hi, if1.result_lo, 16'd0} | 64'({if2.result_hi, if2.result_lo} != 0),
            64'd0);
        chk("midrst/ctl", 64'({if1.busy, if1.done, if1.stall, if2.busy, if2.done, if2.stall}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op("post_rst", 3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
